// File: rtl/traffic_pkg.sv
// Shared types and constants for the junction phase controller and its timer.
// Lamp codes are {red,yellow,green} one-hot.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    PED_WALK  = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic TSEL_LONG  = 1'b1;
  localparam logic TSEL_SHORT = 1'b0;

  localparam logic [3:0] MAX_COUNT_LONG  = 4'd10;
  localparam logic [3:0] MAX_COUNT_SHORT = 4'd3;

endpackage

// File: rtl/traffic_req_latch.sv
// Sticky request bit: set while enabled, cleared when the serving phase is entered.
// Clear outranks a simultaneous set because that phase serves the request.
module traffic_req_latch (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  input  logic enable,
  output logic q
);

  logic q_r;

  // Request latch register with clear priority
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= 1'b0;
    end else if (clr) begin
      q_r <= 1'b0;
    end else if (enable && set) begin
      q_r <= 1'b1;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Phase FSM for the NS/EW junction with pedestrian crossing, stepped by done_pulse.
// Lamp, walk and timer_select outputs are decoded from the next state and registered.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter bit SENSOR_ENABLE = 1'b1,
  parameter bit PED_ENABLE    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_pulse,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic       timer_select,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic [2:0] state_dbg
);

  state_t     state_r, state_next_s;
  logic       ew_q_s, ped_q_s;
  logic       ew_clr_s, ped_clr_s;
  logic [2:0] ns_next_s, ew_next_s;
  logic       walk_next_s, tsel_next_s;
  logic [2:0] ns_r, ew_r;
  logic       walk_r, tsel_r;

  // Next-state selection; only a done_pulse edge advances the phase
  always_comb begin
    state_next_s = NS_GREEN;
    case (state_r)
      NS_GREEN: begin
        if (done_pulse && (!SENSOR_ENABLE || ew_q_s || ped_q_s)) state_next_s = NS_YELLOW;
        else                                                      state_next_s = NS_GREEN;
      end
      NS_YELLOW: state_next_s = done_pulse ? ALL_RED_1 : NS_YELLOW;
      ALL_RED_1: begin
        if (!done_pulse)                    state_next_s = ALL_RED_1;
        else if (ew_q_s || !SENSOR_ENABLE)  state_next_s = EW_GREEN;
        else                                state_next_s = PED_WALK;
      end
      EW_GREEN:  state_next_s = done_pulse ? EW_YELLOW : EW_GREEN;
      EW_YELLOW: state_next_s = done_pulse ? ALL_RED_2 : EW_YELLOW;
      ALL_RED_2: begin
        if (!done_pulse)   state_next_s = ALL_RED_2;
        else if (ped_q_s)  state_next_s = PED_WALK;
        else               state_next_s = NS_GREEN;
      end
      PED_WALK:  state_next_s = done_pulse ? NS_GREEN : PED_WALK;
      default:   state_next_s = NS_GREEN;
    endcase
  end

  // Output decode from the next state so lamps change with the state
  always_comb begin
    ns_next_s   = LAMP_GRN;
    ew_next_s   = LAMP_RED;
    walk_next_s = 1'b0;
    tsel_next_s = TSEL_LONG;
    case (state_next_s)
      NS_GREEN:  begin ns_next_s = LAMP_GRN; ew_next_s = LAMP_RED; walk_next_s = 1'b0; tsel_next_s = TSEL_LONG;  end
      NS_YELLOW: begin ns_next_s = LAMP_YEL; ew_next_s = LAMP_RED; walk_next_s = 1'b0; tsel_next_s = TSEL_SHORT; end
      ALL_RED_1: begin ns_next_s = LAMP_RED; ew_next_s = LAMP_RED; walk_next_s = 1'b0; tsel_next_s = TSEL_SHORT; end
      EW_GREEN:  begin ns_next_s = LAMP_RED; ew_next_s = LAMP_GRN; walk_next_s = 1'b0; tsel_next_s = TSEL_LONG;  end
      EW_YELLOW: begin ns_next_s = LAMP_RED; ew_next_s = LAMP_YEL; walk_next_s = 1'b0; tsel_next_s = TSEL_SHORT; end
      ALL_RED_2: begin ns_next_s = LAMP_RED; ew_next_s = LAMP_RED; walk_next_s = 1'b0; tsel_next_s = TSEL_SHORT; end
      PED_WALK:  begin ns_next_s = LAMP_RED; ew_next_s = LAMP_RED; walk_next_s = 1'b1; tsel_next_s = TSEL_LONG;  end
      default:   begin ns_next_s = LAMP_GRN; ew_next_s = LAMP_RED; walk_next_s = 1'b0; tsel_next_s = TSEL_LONG;  end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= NS_GREEN;
      ns_r    <= LAMP_GRN;
      ew_r    <= LAMP_RED;
      walk_r  <= 1'b0;
      tsel_r  <= TSEL_LONG;
    end else begin
      state_r <= state_next_s;
      ns_r    <= ns_next_s;
      ew_r    <= ew_next_s;
      walk_r  <= walk_next_s;
      tsel_r  <= tsel_next_s;
    end
  end

  // A latch clears on the edge that enters the phase serving it
  assign ew_clr_s  = (state_next_s == EW_GREEN) && (state_r != EW_GREEN);
  assign ped_clr_s = (state_next_s == PED_WALK) && (state_r != PED_WALK);

  traffic_req_latch u_ew_latch (
    .clk    (clk),
    .rst    (rst),
    .set    (ew_car),
    .clr    (ew_clr_s),
    .enable (1'b1),
    .q      (ew_q_s)
  );

  traffic_req_latch u_ped_latch (
    .clk    (clk),
    .rst    (rst),
    .set    (ped_req),
    .clr    (ped_clr_s),
    .enable (PED_ENABLE),
    .q      (ped_q_s)
  );

  assign timer_select = tsel_r;
  assign ns_light     = ns_r;
  assign ew_light     = ew_r;
  assign ped_walk     = walk_r;
  assign state_dbg    = state_r;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: hand-written phase tables per scenario
// plus a continuous check that the two roads are never released together.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done_pulse = 1'b0;
  logic       ew_car = 1'b0;
  logic       ped_req = 1'b0;
  logic       timer_select;
  logic [2:0] ns_light, ew_light, state_dbg;
  logic       ped_walk;

  int compared = 0;
  int mismatched = 0;
  bit mon_en = 1'b0;

  // {state, ns, ew, walk, tsel}
  localparam logic [10:0] R_NSG = 11'b000_001_100_0_1;
  localparam logic [10:0] R_NSY = 11'b001_010_100_0_0;
  localparam logic [10:0] R_AR1 = 11'b010_100_100_0_0;
  localparam logic [10:0] R_EWG = 11'b011_100_001_0_1;
  localparam logic [10:0] R_EWY = 11'b100_100_010_0_0;
  localparam logic [10:0] R_AR2 = 11'b101_100_100_0_0;
  localparam logic [10:0] R_PED = 11'b110_100_100_1_1;

  wire [10:0] obs = {state_dbg, ns_light, ew_light, ped_walk, timer_select};

  traffic_light_ctrl #(.SENSOR_ENABLE(1'b1), .PED_ENABLE(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .done_pulse   (done_pulse),
    .ew_car       (ew_car),
    .ped_req      (ped_req),
    .timer_select (timer_select),
    .ns_light     (ns_light),
    .ew_light     (ew_light),
    .ped_walk     (ped_walk),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      compared++;
      if (ns_light !== 3'b100 && ew_light !== 3'b100) begin
        mismatched++;
        $display("FAIL both_roads_open ns=%b ew=%b", ns_light, ew_light);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    done_pulse = 1'b1;
    tick();
    done_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    compared++;
    if (obs !== R_NSG) begin
      mismatched++;
      $display("FAIL reset_state got=%b exp=%b", obs, R_NSG);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      repeat (9) tick();
      pulse_done();
      compared++;
      if (obs !== R_NSG) begin
        mismatched++;
        $display("FAIL idle_hold[%0d] got=%b exp=%b", i, obs, R_NSG);
      end
    end
  endtask

  task automatic test_ew_cycle();
    logic [10:0] seq [7] = '{R_NSY, R_AR1, R_EWG, R_EWY, R_AR2, R_NSG, R_NSG};
    repeat (5) tick();
    ew_car = 1'b1;
    tick();
    ew_car = 1'b0;
    repeat (3) tick();
    compared++;
    if (obs !== R_NSG) begin
      mismatched++;
      $display("FAIL ew_wait got=%b exp=%b", obs, R_NSG);
    end
    for (int i = 0; i < 7; i++) begin
      repeat (2) tick();
      pulse_done();
      compared++;
      if (obs !== seq[i]) begin
        mismatched++;
        $display("FAIL ew_cycle[%0d] got=%b exp=%b", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_ped_only();
    logic [10:0] seq [5] = '{R_NSY, R_AR1, R_PED, R_NSG, R_NSG};
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (2) tick();
      pulse_done();
      compared++;
      if (obs !== seq[i]) begin
        mismatched++;
        $display("FAIL ped_only[%0d] got=%b exp=%b", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_both();
    logic [10:0] seq [8] = '{R_NSY, R_AR1, R_EWG, R_EWY, R_AR2, R_PED, R_NSG, R_NSG};
    ew_car  = 1'b1;
    ped_req = 1'b1;
    tick();
    ew_car  = 1'b0;
    ped_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (2) tick();
      if (i == 5) ped_req = 1'b1;
      pulse_done();
      ped_req = 1'b0;
      compared++;
      if (obs !== seq[i]) begin
        mismatched++;
        $display("FAIL both_req[%0d] got=%b exp=%b", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [10:0] seq [6] = '{R_NSY, R_AR1, R_EWG, R_EWY, R_AR2, R_NSG};
    repeat (2) tick();
    ew_car     = 1'b1;
    done_pulse = 1'b1;
    tick();
    ew_car     = 1'b0;
    done_pulse = 1'b0;
    compared++;
    if (obs !== R_NSG) begin
      mismatched++;
      $display("FAIL same_cycle_hold got=%b exp=%b", obs, R_NSG);
    end
    for (int i = 0; i < 6; i++) begin
      repeat (2) tick();
      pulse_done();
      compared++;
      if (obs !== seq[i]) begin
        mismatched++;
        $display("FAIL same_cycle[%0d] got=%b exp=%b", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    ew_car = 1'b1;
    tick();
    ew_car = 1'b0;
    for (int i = 0; i < 3; i++) pulse_done();
    compared++;
    if (obs !== R_EWG) begin
      mismatched++;
      $display("FAIL mid_pre_reset got=%b exp=%b", obs, R_EWG);
    end
    ew_car  = 1'b1;
    ped_req = 1'b1;
    tick();
    ew_car  = 1'b0;
    ped_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    compared++;
    if (obs !== R_NSG) begin
      mismatched++;
      $display("FAIL mid_reset got=%b exp=%b", obs, R_NSG);
    end
    repeat (2) tick();
    pulse_done();
    compared++;
    if (obs !== R_NSG) begin
      mismatched++;
      $display("FAIL mid_latches_cleared got=%b exp=%b", obs, R_NSG);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_ew_cycle();
    test_ped_only();
    test_both();
    test_same_cycle();
    test_reset_mid();
    repeat (3) tick();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
